// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared constants for the ID-stage scoreboard slice: RV32I major opcodes,
// the scoreboard FSM state encoding, counter sizing and the saturating
// per-register counter update helper.
package riscv_pkg;

    // RV32I major opcodes (inst[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int         NUM_REGS = 32;
    localparam logic [1:0] CNT_MAX  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // All same-edge events on one register are folded into a single net
    // change and clamped, so a decrement of an empty counter is lost
    // rather than wrapping.
    function automatic logic [1:0] satUpdate(input logic [1:0] cnt,
                                             input logic       inc,
                                             input logic       decA,
                                             input logic       decB);
        int v;
        v = int'(cnt) + int'(inc) - int'(decA) - int'(decB);
        if (v < 0) begin
            v = 0;
        end else if (v > int'(CNT_MAX)) begin
            v = int'(CNT_MAX);
        end
        return v[1:0];
    endfunction

endpackage

// File: rtl/id_scoreboard_ctrl_if.sv
// id_scoreboard_ctrl_if
// Bundles the ID-stage request, writeback/kill retirement, drain request and
// scoreboard status signals.
//   slave  : the scoreboard controller (consumes requests, drives status)
//   master : the pipeline side driving ID/WB/kill/drain
interface id_scoreboard_ctrl_if;

    logic        id_valid;
    logic [31:0] id_inst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        kill_valid;
    logic [4:0]  kill_rd;
    logic        drain_req;
    logic        id_ready;
    logic        issue;
    logic        stall;
    logic [31:0] busy;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    modport slave (
        input  id_valid, id_inst, wb_valid, wb_rd, kill_valid, kill_rd, drain_req,
        output id_ready, issue, stall, busy, state, stall_cnt
    );

    modport master (
        output id_valid, id_inst, wb_valid, wb_rd, kill_valid, kill_rd, drain_req,
        input  id_ready, issue, stall, busy, state, stall_cnt
    );

endinterface

// File: rtl/reg_use_decode.sv
// reg_use_decode
// Maps an RV32I major opcode to which register fields the instruction uses.
//   opcode  in  7  inst[6:0]
//   use_rs1 out 1  rs1 is read
//   use_rs2 out 1  rs2 is read
//   use_rd  out 1  rd is written
// Unknown opcodes use no registers.
module reg_use_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       use_rs1,
    output logic       use_rs2,
    output logic       use_rd
);

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: begin
                use_rd  = 1'b1;
            end
            OP_REG: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/id_scoreboard_ctrl.sv
// id_scoreboard_ctrl
// ID-stage register scoreboard: a 2-bit pending-write counter per register
// x1..x31 gates issue on RAW hazards and on counter saturation, and a small
// RUN/STALL/DRAIN FSM handles stalls and full pipeline drains.
//   clk    in  1   rising-edge clock
//   reset  in  1   asynchronous active-low reset
//   bus    slave   id_valid/id_inst, wb_valid/wb_rd, kill_valid/kill_rd,
//                  drain_req in; id_ready, issue, stall, busy, state,
//                  stall_cnt out
module id_scoreboard_ctrl
    import riscv_pkg::*;
(
    input logic                 clk,
    input logic                 reset,
    id_scoreboard_ctrl_if.slave bus
);

    logic        w_useRs1;
    logic        w_useRs2;
    logic        w_useRd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [1:0]  r_cnt [NUM_REGS];
    logic [1:0]  w_cntNext [NUM_REGS];
    logic [31:0] w_busy;
    logic        w_hazard;
    logic        w_ready;
    logic        w_issue;
    logic        w_stall;
    logic        w_allZero;
    logic        w_unusedInstBits;
    state_e      r_state;
    logic [15:0] r_stallCnt;

    assign w_rs1 = bus.id_inst[19:15];
    assign w_rs2 = bus.id_inst[24:20];
    assign w_rd  = bus.id_inst[11:7];
    assign w_unusedInstBits = ^{bus.id_inst[31:25], bus.id_inst[14:12]};

    reg_use_decode u_decode (
        .opcode  (bus.id_inst[6:0]),
        .use_rs1 (w_useRs1),
        .use_rs2 (w_useRs2),
        .use_rd  (w_useRd)
    );

    // x0 is never tracked, so its busy bit is tied low.
    always_comb begin
        w_busy = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_busy[i] = (r_cnt[i] != 2'd0);
        end
    end

    // Hazard looks only at registered counters: a writeback in this cycle
    // does not unblock the instruction until the next cycle.
    assign w_hazard  = (w_useRs1 && w_busy[w_rs1])
                     || (w_useRs2 && w_busy[w_rs2])
                     || (w_useRd && (w_rd != 5'd0) && (r_cnt[w_rd] == CNT_MAX));
    assign w_ready   = (r_state == ST_RUN) && !w_hazard;
    assign w_issue   = bus.id_valid && w_ready;
    assign w_stall   = bus.id_valid && !w_ready;
    assign w_allZero = (w_busy == 32'h0);

    always_comb begin
        w_cntNext[0] = 2'd0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_cntNext[i] = satUpdate(r_cnt[i],
                                     w_issue && w_useRd && (w_rd == 5'(i)),
                                     bus.wb_valid && (bus.wb_rd == 5'(i)),
                                     bus.kill_valid && (bus.kill_rd == 5'(i)));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= w_cntNext[i];
            end
        end
    end

    // drain_req overrides every other transition; DRAIN exits only after a
    // full cycle of observing an empty scoreboard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else if (bus.drain_req) begin
            r_state <= ST_DRAIN;
        end else begin
            case (r_state)
                ST_RUN:   if (w_stall)   r_state <= ST_STALL;
                ST_STALL: if (!w_hazard) r_state <= ST_RUN;
                ST_DRAIN: if (w_allZero) r_state <= ST_RUN;
                default:                 r_state <= ST_RUN;
            endcase
        end
    end

    // Counts cycles where ID holds a valid instruction it cannot issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stallCnt <= 16'd0;
        end else if ((w_stall || ((r_state == ST_DRAIN) && bus.id_valid))
                     && (r_stallCnt != 16'hFFFF)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end

    assign bus.id_ready  = w_ready;
    assign bus.issue     = w_issue;
    assign bus.stall     = w_stall;
    assign bus.busy      = w_busy;
    assign bus.state     = r_state;
    assign bus.stall_cnt = r_stallCnt;

endmodule
